// File: rtl/cpu_control_fsm.sv
// ============================================================================
//  Module   : cpu_control_fsm
//  Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
//             the 16-bit SPU datapath; owns PC and IR.
//  Options  : CPU_CTRL_ILLEGAL_TRAP_EN - trap illegal opcodes into HALT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [2:0]  reg_read_address_1,
  output logic [2:0]  reg_read_address_2,
  output logic [2:0]  reg_write_destination,
  output logic        reg_write_enable,
  output logic [2:0]  alu_control,
  output logic        alu_src_imm,
  output logic [15:0] imm_ext,
  output logic        memory_read,
  output logic        memory_write_enable,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        halted
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_op
`endif
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_ALU = 4'h2;
  localparam logic [3:0] OP_BEQ = 4'h3;
  localparam logic [3:0] OP_BNE = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  // An odd reset vector is forced even so pc[0] can never be set.
  localparam logic [15:0] C_PC_RESET = {PC_RESET[15:1], 1'b0};

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  w_op;
  logic        w_taken;
  logic        w_exec_phase;

  assign w_op    = ir_q[15:12];
  assign w_taken = (w_op == OP_BEQ) ? alu_zero : ~alu_zero;

  assign pc                    = pc_q;
  assign state                 = state_q;
  assign halted                = (state_q == S_HALT);
  assign reg_read_address_1    = ir_q[11:9];
  assign reg_read_address_2    = ir_q[8:6];
  assign reg_write_destination = (w_op == OP_LD) ? ir_q[8:6] : ir_q[5:3];
  assign imm_ext               = {{10{ir_q[5]}}, ir_q[5:0]};

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_op = illegal_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instruction;
          pc_d    = pc_q + 16'd2;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_JMP: begin
            pc_d    = {pc_q[15:13], ir_q[11:0], 1'b0};
            state_d = S_FETCH;
          end
          OP_HLT: state_d = S_HALT;
          OP_LD, OP_ST, OP_ALU, OP_BEQ, OP_BNE: state_d = S_EXECUTE;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HALT;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_EXECUTE: begin
        case (w_op)
          OP_ALU:       state_d = S_WRITEBACK;
          OP_LD, OP_ST: state_d = S_MEMORY;
          OP_BEQ, OP_BNE: begin
            // pc already points past the branch; offset is in halfwords.
            if (w_taken) pc_d = pc_q + {imm_ext[14:0], 1'b0};
            state_d = S_FETCH;
          end
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready) state_d = (w_op == OP_LD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= C_PC_RESET;
      ir_q    <= 16'h0000;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign w_exec_phase = (state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
                        (state_q == S_WRITEBACK);

  // Strobes are masked by reset so an interrupted store never writes.
  always_comb begin
    reg_write_enable    = 1'b0;
    alu_control         = 3'b000;
    alu_src_imm         = 1'b0;
    memory_read         = 1'b0;
    memory_write_enable = 1'b0;
    mem_to_reg          = 1'b0;
    if (!reset && w_exec_phase) begin
      case (w_op)
        OP_LD, OP_ST:   alu_src_imm = 1'b1;
        OP_ALU:         alu_control = ir_q[2:0];
        OP_BEQ, OP_BNE: alu_control = 3'b001;
        default:        alu_control = 3'b000;
      endcase
      if (state_q == S_MEMORY) begin
        memory_read         = (w_op == OP_LD);
        memory_write_enable = (w_op == OP_ST);
      end
      if (state_q == S_WRITEBACK) begin
        reg_write_enable = 1'b1;
        mem_to_reg       = (w_op == OP_LD);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
// ============================================================================
//  Module   : tb_cpu_control_fsm
//  Purpose  : Directed plus randomized instruction-level check of cpu_control_fsm
//             against a per-instruction reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_fsm;

  localparam logic [15:0] PC_RST = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, run, alu_zero, mem_ready;
  logic [15:0] instruction;
  logic [15:0] pc, imm_ext;
  logic [2:0]  reg_read_address_1, reg_read_address_2, reg_write_destination;
  logic        reg_write_enable, alu_src_imm, memory_read, memory_write_enable;
  logic        mem_to_reg, halted;
  logic [2:0]  alu_control, state;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  cpu_control_fsm #(.PC_RESET(PC_RST)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .run                   (run),
    .instruction           (instruction),
    .alu_zero              (alu_zero),
    .mem_ready             (mem_ready),
    .pc                    (pc),
    .reg_read_address_1    (reg_read_address_1),
    .reg_read_address_2    (reg_read_address_2),
    .reg_write_destination (reg_write_destination),
    .reg_write_enable      (reg_write_enable),
    .alu_control           (alu_control),
    .alu_src_imm           (alu_src_imm),
    .imm_ext               (imm_ext),
    .memory_read           (memory_read),
    .memory_write_enable   (memory_write_enable),
    .mem_to_reg            (mem_to_reg),
    .state                 (state),
    .halted                (halted)
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op            (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] pc_m;

  typedef struct {
    int          cyc;
    int          rd;
    int          wr;
    int          we;
    bit          m2r;
    logic [2:0]  dest;
    logic [2:0]  ctl;
    bit          imm;
    bit          has_exec;
    bit          halt;
    bit          ill;
    logic [15:0] npc;
  } exp_t;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic strobes();
    return reg_write_enable | memory_read | memory_write_enable | mem_to_reg;
  endfunction

  // Instruction-level expectations computed from the ISA rules.
  function automatic exp_t predict(input logic [15:0] ins, input logic [15:0] cur_pc,
                                   input bit z, input int w);
    exp_t        e;
    logic [15:0] pc1;
    int          simm;
    e    = '{default: 0};
    pc1  = cur_pc + 16'd2;
    simm = $signed(ins[5:0]);
    e.npc = pc1;
    e.cyc = 2;
    case (ins[15:12])
      4'h0: begin
        e.cyc = 5 + w; e.rd = 1 + w; e.we = 1; e.m2r = 1; e.dest = ins[8:6];
        e.has_exec = 1; e.imm = 1; e.ctl = 3'b000;
      end
      4'h1: begin
        e.cyc = 4 + w; e.wr = 1 + w; e.has_exec = 1; e.imm = 1; e.ctl = 3'b000;
      end
      4'h2: begin
        e.cyc = 4; e.we = 1; e.dest = ins[5:3]; e.has_exec = 1; e.ctl = ins[2:0];
      end
      4'h3, 4'h4: begin
        e.cyc = 3; e.has_exec = 1; e.ctl = 3'b001;
        if ((ins[15:12] == 4'h3) == z) e.npc = pc1 + 16'(simm * 2);
      end
      4'h5: e.npc = (pc1 & 16'hE000) | 16'(int'(ins[11:0]) * 2);
      4'hF: e.halt = 1;
      default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        e.halt = 1; e.ill = 1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; instruction = 16'h0000;
    tick();
    reset = 1'b0;
    pc_m  = PC_RST;
    check({tag, "_state"},  16'(state), 16'd0);
    check({tag, "_pc"},     pc, PC_RST);
    check({tag, "_halted"}, 16'(halted), 16'd0);
    check({tag, "_strobes"}, 16'(strobes()), 16'd0);
    check({tag, "_ir_rs"},  16'({reg_read_address_1, reg_read_address_2}), 16'd0);
    check({tag, "_imm"},    imm_ext, 16'h0000);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    check({tag, "_illegal"}, 16'(illegal_op), 16'd0);
`endif
  endtask

  // Runs one instruction from FETCH until the FSM is back in FETCH or in HALT.
  task automatic exec(input logic [15:0] ins, input bit z, input int w, input string tag);
    exp_t        e;
    int          n = 0, rd = 0, wr = 0, we = 0, memcnt = 0, early = 0;
    logic        m2r = 1'b0, imm = 1'b0;
    logic [2:0]  dest = 3'd0, ctl = 3'd0, rs1 = 3'd0, rs2 = 3'd0;
    logic [15:0] immx = 16'h0000;
    e = predict(ins, pc_m, z, w);
    instruction = ins; alu_zero = z; run = 1'b1;
    do begin
      if (memory_read) rd++;
      if (memory_write_enable) wr++;
      if (reg_write_enable) begin we++; m2r = mem_to_reg; dest = reg_write_destination; end
      if (state == 3'd2) begin
        ctl = alu_control; imm = alu_src_imm;
        rs1 = reg_read_address_1; rs2 = reg_read_address_2; immx = imm_ext;
      end
      if (n < 2 && strobes()) early++;
      if (memory_read || memory_write_enable) begin
        mem_ready = (memcnt >= w);
        memcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      tick();
      n++;
      instruction = 16'($urandom);
      run = 1'($urandom);
    end while (state != 3'd0 && state != 3'd5 && n < 40);
    mem_ready = 1'b0;
    check({tag, "_cycles"}, 16'(n), 16'(e.cyc));
    check({tag, "_rd"},     16'(rd), 16'(e.rd));
    check({tag, "_wr"},     16'(wr), 16'(e.wr));
    check({tag, "_we"},     16'(we), 16'(e.we));
    check({tag, "_early"},  16'(early), 16'd0);
    if (e.we != 0) begin
      check({tag, "_m2r"},  16'(m2r), 16'(e.m2r));
      check({tag, "_dest"}, 16'(dest), 16'(e.dest));
    end
    if (e.has_exec) begin
      check({tag, "_ctl"},  16'(ctl), 16'(e.ctl));
      check({tag, "_srci"}, 16'(imm), 16'(e.imm));
      check({tag, "_rs"},   16'({rs1, rs2}), 16'({ins[11:9], ins[8:6]}));
      check({tag, "_immx"}, immx, 16'($signed(ins[5:0])));
    end
    check({tag, "_pc"},     pc, e.npc);
    check({tag, "_halted"}, 16'(halted), 16'(e.halt));
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    check({tag, "_illegal"}, 16'(illegal_op), 16'(e.ill));
`endif
    pc_m = e.npc;
  endtask

  initial begin
    int          frozen;
    logic [3:0]  op;
    logic [15:0] pc_hold;

    reset = 1'b1; run = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0; instruction = 16'h0000;
    do_reset("reset0");

    run = 1'b0; instruction = 16'h2A98;
    repeat (5) tick();
    check("hold_state", 16'(state), 16'd0);
    check("hold_pc", pc, PC_RST);

    exec(16'h2A98, 1'b0, 0, "alu");
    check("alu_pc_abs", pc, 16'h0002);
    exec(16'h303E, 1'b1, 0, "beq_taken");
    exec(16'h303E, 1'b1, 0, "beq_back");
    check("beq_back_abs", pc, 16'hFFFE);
    exec(16'h2A98, 1'b0, 0, "wrap");
    check("wrap_abs", pc, 16'h0000);
    exec(16'h0283, 1'b0, 2, "ld_w2");
    exec(16'h403E, 1'b1, 0, "bne_not_taken");
    exec(16'h403E, 1'b0, 0, "bne_taken");
    exec(16'h1283, 1'b0, 1, "st_w1");
    exec(16'h5FFF, 1'b0, 0, "jmp_a");
    exec(16'h2A98, 1'b0, 0, "step_a");
    exec(16'h5FFF, 1'b0, 0, "jmp_b");
    exec(16'h2A98, 1'b0, 0, "step_b");
    check("at_4000", pc, 16'h4000);
    exec(16'h5123, 1'b0, 0, "jmp_c");
    check("jmp_4246", pc, 16'h4246);

    for (int i = 0; i < 300; i++) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      op = 4'($urandom_range(0, 5));
`else
      op = 4'($urandom_range(0, 14));
`endif
      exec({op, 12'($urandom)}, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    instruction = 16'h1283; run = 1'b1; mem_ready = 1'b0;
    repeat (3) tick();
    check("strst_in_mem", 16'(memory_write_enable), 16'd1);
    reset = 1'b1;
    #1;
    check("strst_no_we_reset_cycle", 16'(memory_write_enable), 16'd0);
    tick();
    reset = 1'b0; run = 1'b0; pc_m = PC_RST;
    check("strst_state", 16'(state), 16'd0);
    check("strst_pc", pc, PC_RST);
    tick();
    check("strst_no_we_after", 16'(memory_write_enable), 16'd0);

    exec(16'h7000, 1'b0, 0, "illegal");
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    check("illegal_state", 16'(state), 16'd5);
    do_reset("reset_ill");
`else
    check("illegal_nop_state", 16'(state), 16'd0);
`endif

    exec(16'hF000, 1'b0, 0, "hlt");
    pc_hold = pc;
    frozen  = 0;
    for (int i = 0; i < 100; i++) begin
      run = 1'($urandom); instruction = 16'($urandom);
      alu_zero = 1'($urandom); mem_ready = 1'($urandom);
      tick();
      if (pc !== pc_hold || halted !== 1'b1 || state !== 3'd5 || strobes()) frozen++;
    end
    check("halt_frozen", 16'(frozen), 16'd0);
    do_reset("reset_hlt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
